// File: rtl/ps2_port.sv
// PS/2 host-side link layer: device->host byte receiver and host->device command sender.
// Optional PS2_GLITCH_FILTER_EN: an 8-cycle stability filter after the pin synchronisers.
module ps2_port #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       rx_err,
   output logic       tx_err,
   output logic       overrun
);

   localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] INH_PRE  = CW'(INH_CYC - 2);
   localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX,
      S_TX_INH,
      S_TX_REQ,
      S_TX_BITS,
      S_TX_ACK,
      S_TX_WAIT
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning: index 0 = PS/2 clock, index 1 = PS/2 data
   // ---------------------------------------------------------------
   logic [1:0] pin_raw;
   logic [1:0] line_s;

   assign pin_raw = {ps2_dat_i, ps2_clk_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_line
         logic meta_q;
         logic sync_q;

         // Reset to 0 so the first rise after reset can never look like a falling edge.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               meta_q <= 1'b0;
               sync_q <= 1'b0;
            end else begin
               meta_q <= pin_raw[gi];
               sync_q <= meta_q;
            end
         end

`ifdef PS2_GLITCH_FILTER_EN
         logic [2:0] stab_q, stab_d;
         logic       filt_q, filt_d;

         // Follow the synchronised pin only after it has differed for 8 cycles in a row.
         always_comb begin
            stab_d = 3'd0;
            filt_d = filt_q;
            if (sync_q != filt_q) begin
               if (stab_q == 3'd7) begin
                  filt_d = sync_q;
               end else begin
                  stab_d = stab_q + 3'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stab_q <= 3'd0;
               filt_q <= 1'b0;
            end else begin
               stab_q <= stab_d;
               filt_q <= filt_d;
            end
         end

         assign line_s[gi] = filt_q;
`else
         assign line_s[gi] = sync_q;
`endif
      end
   endgenerate

   logic clk_s, dat_s;
   assign clk_s = line_s[0];
   assign dat_s = line_s[1];

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_par_q, rx_par_d;
   logic [8:0]      tx_shift_q, tx_shift_d;
   logic            clk_s_q, fall_q, fall_d;
   logic            clk_oe_q, clk_oe_d;
   logic            dat_oe_q, dat_oe_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_err_q, rx_err_d;
   logic            tx_err_q, tx_err_d;
   logic            overrun_q, overrun_d;
   logic            to_hit;
   logic            frame_good;

   assign fall_d     = clk_s_q & ~clk_s;
   assign to_hit     = (cnt_q == TO_LAST);
   assign frame_good = (^{rx_shift_q, rx_par_q}) & dat_s;
   assign tx_ready   = (state_q == S_IDLE) && !fall_q && clk_s && dat_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      tx_shift_d = tx_shift_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q && !rx_ready;
      rx_err_d   = 1'b0;
      tx_err_d   = 1'b0;
      overrun_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_cnt_d = 4'd0;
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            if (fall_q && !dat_s) begin
               state_d = S_RX;
            end else if (tx_valid && tx_ready) begin
               tx_shift_d = {~^tx_data, tx_data};
               clk_oe_d   = 1'b1;
               state_d    = S_TX_INH;
            end
         end

         S_RX: begin
            if (fall_q) begin
               cnt_d = '0;
               if (bit_cnt_q < 4'd8) begin
                  rx_shift_d = {dat_s, rx_shift_q[7:1]};
                  bit_cnt_d  = bit_cnt_q + 4'd1;
               end else if (bit_cnt_q == 4'd8) begin
                  rx_par_d  = dat_s;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
                  // Stop bit: a byte may load in the same cycle the old one is taken.
                  if (!frame_good) begin
                     rx_err_d = 1'b1;
                  end else if (rx_valid_q && !rx_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     rx_data_d  = rx_shift_q;
                     rx_valid_d = 1'b1;
                  end
                  bit_cnt_d = 4'd0;
                  state_d   = S_IDLE;
               end
            end else if (to_hit) begin
               rx_err_d  = 1'b1;
               bit_cnt_d = 4'd0;
               state_d   = S_IDLE;
            end
         end

         S_TX_INH: begin
            clk_oe_d = 1'b1;
            // Data goes low while the clock is still held, giving the start bit.
            if (cnt_q == INH_PRE) begin
               dat_oe_d = 1'b1;
            end
            if (cnt_q == INH_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_TX_REQ;
            end
         end

         S_TX_REQ: begin
            if (fall_q) begin
               cnt_d      = '0;
               dat_oe_d   = ~tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[8:1]};
               bit_cnt_d  = 4'd1;
               state_d    = S_TX_BITS;
            end else if (to_hit) begin
               tx_err_d = 1'b1;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               state_d  = S_IDLE;
            end
         end

         S_TX_BITS: begin
            if (fall_q) begin
               cnt_d = '0;
               if (bit_cnt_q == 4'd9) begin
                  dat_oe_d = 1'b0;
                  state_d  = S_TX_ACK;
               end else begin
                  dat_oe_d   = ~tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[8:1]};
                  bit_cnt_d  = bit_cnt_q + 4'd1;
               end
            end else if (to_hit) begin
               tx_err_d = 1'b1;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               state_d  = S_IDLE;
            end
         end

         S_TX_ACK: begin
            if (fall_q) begin
               cnt_d    = '0;
               tx_err_d = dat_s;
               state_d  = S_TX_WAIT;
            end else if (to_hit) begin
               tx_err_d = 1'b1;
               state_d  = S_IDLE;
            end
         end

         S_TX_WAIT: begin
            if (clk_s && dat_s) begin
               state_d = S_IDLE;
            end else if (fall_q) begin
               cnt_d = '0;
            end else if (to_hit) begin
               tx_err_d = 1'b1;
               state_d  = S_IDLE;
            end
         end

         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= 4'd0;
         rx_shift_q <= 8'h00;
         rx_par_q   <= 1'b0;
         tx_shift_q <= 9'h000;
         clk_s_q    <= 1'b0;
         fall_q     <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         tx_err_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         tx_shift_q <= tx_shift_d;
         clk_s_q    <= clk_s;
         fall_q     <= fall_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         tx_err_q   <= tx_err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_err     = rx_err_q;
   assign tx_err     = tx_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: open-drain bus model, PS/2 device model and a scoreboard monitor
// for received bytes, error/overrun pulses and bytes the host sends to the device.
module tb_ps2_port;

   localparam int CLK_HZ     = 1_000_000;
   localparam int INHIBIT_US = 100;
   localparam int TIMEOUT_US = 2000;
   localparam int INH        = 100;   // 1 cycle/us * 100 us
   localparam int TO         = 2000;  // 1 cycle/us * 2000 us
   localparam int HALF       = 40;    // device clock half period in system clocks

   localparam int EV_NONE  = 0;
   localparam int EV_RXERR = 1;
   localparam int EV_OVR   = 2;
   localparam int EV_TXERR = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk_i, ps2_dat_i;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       rx_err, tx_err, overrun;

   assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

   always #10 clk = ~clk;

   ps2_port #(
      .CLK_HZ    (CLK_HZ),
      .INHIBIT_US(INHIBIT_US),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk_i (ps2_clk_i),
      .ps2_dat_i (ps2_dat_i),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_err    (rx_err),
      .tx_err    (tx_err),
      .overrun   (overrun)
   );

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_rx[$];
   int          exp_ev[$];
   logic [8:0]  exp_tx[$];
   logic [31:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic ev_seen(input int code);
      int e;
      e = (exp_ev.size() > 0) ? exp_ev.pop_front() : EV_NONE;
      check("event", code, e);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_valid && rx_ready) begin
            mon_exp = (exp_rx.size() > 0) ? {24'h0, exp_rx.pop_front()} : 32'hDEAD;
            check("rx_byte", {24'h0, rx_data}, mon_exp);
         end
         if (rx_err)  ev_seen(EV_RXERR);
         if (overrun) ev_seen(EV_OVR);
         if (tx_err)  ev_seen(EV_TXERR);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Device -> host frame; nbits < 11 sends only the first nbits bit periods
   task automatic dev_send(input logic [7:0] b, input logic flip_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat_low = ~fr[i];
         tick(HALF / 2);
         dev_clk_low = 1'b1;
         tick(HALF);
         dev_clk_low = 1'b0;
         tick(HALF / 2);
      end
      if (nbits == 11) dev_dat_low = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 1000) begin
         tick(1);
         n++;
      end
      check("tx_ready_idle", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   // Device side of a host->device frame: inhibit, start bit, nclk clock pulses
   task automatic dev_recv(input logic ack, input int nclk);
      int n;
      logic [10:0] got;
      logic [31:0] e;
      check("inh_start", ps2_clk_oe, 1);
      check("tx_busy", tx_ready, 0);
      n = 0;
      while (ps2_clk_oe && n < 10 * INH) begin
         tick(1);
         n++;
      end
      check("inh_len", n, INH);
      check("start_bit", ps2_dat_oe, 1);
      tick(30);
      got = '0;
      for (int i = 0; i < nclk; i++) begin
         if (i == 10 && ack) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         tick(HALF);
         got[i] = ps2_dat_i;
         dev_clk_low = 1'b0;
         tick(HALF);
      end
      dev_dat_low = 1'b0;
      if (nclk == 11) begin
         e = (exp_tx.size() > 0) ? {23'h0, exp_tx.pop_front()} : 32'hDEAD;
         check("tx_frame", {23'h0, got[8:0]}, e);
         check("tx_stop", got[9], 1);
      end
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int gap;

      // Reset state
      tick(5);
      check("rst_outs", {ps2_clk_oe, ps2_dat_oe, rx_valid, tx_ready, rx_err, tx_err, overrun, rx_data}, 0);
      reset_n = 1'b1;
      tick(50);
      check("idle_tx_ready", tx_ready, 1);

      // 0xAA with rx_ready high
      exp_rx.push_back(8'hAA);
      dev_send(8'hAA, 1'b0, 11);
      tick(100);

      // 0x1C held, then 0xF0 overruns
      rx_ready = 1'b0;
      exp_rx.push_back(8'h1C);
      dev_send(8'h1C, 1'b0, 11);
      tick(100);
      exp_ev.push_back(EV_OVR);
      dev_send(8'hF0, 1'b0, 11);
      tick(20);
      check("hold_valid", rx_valid, 1);
      check("hold_data", rx_data, 8'h1C);
      rx_ready = 1'b1;
      tick(1);
      check("valid_drop", rx_valid, 0);
      tick(100);

      // 0x1D with bad parity
      exp_ev.push_back(EV_RXERR);
      dev_send(8'h1D, 1'b1, 11);
      tick(20);
      check("par_err_no_valid", rx_valid, 0);
      tick(100);

      // Command 0xFF, device acknowledges (odd parity 1)
      exp_tx.push_back(9'h1FF);
      send_cmd(8'hFF);
      dev_recv(1'b1, 11);
      n = 0;
      while (!tx_ready && n < 500) begin
         tick(1);
         n++;
      end
      check("tx_ready_back", tx_ready, 1);
      check("lines_free", {ps2_clk_oe, ps2_dat_oe}, 0);
      tick(100);

      // Command 0xF4, device stops clocking after 4 pulses
      exp_ev.push_back(EV_TXERR);
      send_cmd(8'hF4);
      dev_recv(1'b0, 4);
      n = 0;
      while (!tx_err && n < 3 * TO) begin
         tick(1);
         n++;
      end
      gap = n + 2 * HALF;
      check("to_window", (gap >= TO && gap <= TO + 20), 1);
      check("to_release", {ps2_clk_oe, ps2_dat_oe}, 0);
      tick(5);
      check("to_idle", tx_ready, 1);
      tick(100);

      // Reset during RX bit 4 while an unconsumed byte is held
      rx_ready = 1'b0;
      dev_send(8'h6B, 1'b0, 11);
      tick(100);
      check("pre_rst_valid", rx_valid, 1);
      dev_send(8'h55, 1'b0, 5);
      dev_dat_low = 1'b0;   // bit 4 of 0x55 is 1
      tick(HALF / 2);
      dev_clk_low = 1'b1;
      tick(10);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_outs", {ps2_clk_oe, ps2_dat_oe, rx_valid, tx_ready, rx_err, tx_err, overrun, rx_data}, 0);
      tick(10);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      tick(20);
      reset_n  = 1'b1;
      rx_ready = 1'b1;
      tick(50);
      exp_rx.push_back(8'h29);
      dev_send(8'h29, 1'b0, 11);
      tick(100);

      check("rx_left", exp_rx.size(), 0);
      check("ev_left", exp_ev.size(), 0);
      check("tx_left", exp_tx.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
